countdown_min_sec_timer: RTL

//  Consumer of the minute digits produced by the minute-setting path: loads MM:SS digits
//  (minutes from the setting path, seconds forced to 00), counts down once per 1 Hz enable

---
 rtl/countdown_min_sec_timer_if.sv | 28 ++
 rtl/countdown_min_sec_timer.sv | 101 ++++++++++
 2 files changed

// File: rtl/countdown_min_sec_timer_if.sv
// countdown_min_sec_timer_if: control/data bundle between the minute-setting path,
// the countdown timer and the display/buzzer drivers.
//   tick, load, min_tens_in, min_ones_in, start_pause, clear : controller -> timer
//   min_tens, min_ones, sec_tens, sec_ones                    : BCD display digits
//   running, done, alarm                                      : status to buzzer/LEDs
interface countdown_min_sec_timer_if;
    logic       tick;
    logic       load;
    logic [3:0] min_tens_in;
    logic [3:0] min_ones_in;
    logic       start_pause;
    logic       clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       alarm;
    modport master (
        output tick, load, min_tens_in, min_ones_in, start_pause, clear,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );
    modport slave (
        input  tick, load, min_tens_in, min_ones_in, start_pause, clear,
        output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );
endinterface

// File: rtl/countdown_min_sec_timer.sv
// countdown_min_sec_timer: MM:SS BCD countdown with start/pause, done pulse and timed alarm.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of countdown_min_sec_timer_if (controls in, digits/status out)
module countdown_min_sec_timer #(
    parameter int ALARM_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    countdown_min_sec_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);
    state_t     state, state_n;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] min_tens_n, min_ones_n, sec_tens_n, sec_ones_n;
    logic [3:0] ld_tens, ld_ones;
    logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
    logic [7:0] cnt, cnt_n, cnt_inc;
    logic       done, done_n;
    logic       is_zero, is_one, borrow_sec, borrow_min;
    assign ld_tens = bus.min_tens_in > 4'd5 ? 4'd5 : bus.min_tens_in;
    assign ld_ones = bus.min_ones_in > 4'd9 ? 4'd9 : bus.min_ones_in;
    assign is_zero = min_tens == 4'd0 && min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd0;
    assign is_one  = min_tens == 4'd0 && min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd1;
    // Borrow chain: each digit wraps to its maximum and passes the borrow upward.
    assign borrow_sec   = sec_ones == 4'd0 && sec_tens == 4'd0;
    assign borrow_min   = borrow_sec && min_ones == 4'd0;
    assign dec_sec_ones = sec_ones == 4'd0 ? 4'd9 : sec_ones - 4'd1;
    assign dec_sec_tens = sec_ones != 4'd0 ? sec_tens : (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1);
    assign dec_min_ones = !borrow_sec ? min_ones : (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1);
    assign dec_min_tens = borrow_min ? min_tens - 4'd1 : min_tens;
    assign cnt_inc      = cnt + 8'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            cnt      <= 8'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            min_tens <= min_tens_n;
            min_ones <= min_ones_n;
            sec_tens <= sec_tens_n;
            sec_ones <= sec_ones_n;
            cnt      <= cnt_n;
            done     <= done_n;
        end
    end
    always_comb begin
        state_n    = state;
        min_tens_n = min_tens;
        min_ones_n = min_ones;
        sec_tens_n = sec_tens;
        sec_ones_n = sec_ones;
        cnt_n      = cnt;
        done_n     = 1'b0;
        if (bus.clear) begin
            state_n    = IDLE;
            min_tens_n = 4'd0;
            min_ones_n = 4'd0;
            sec_tens_n = 4'd0;
            sec_ones_n = 4'd0;
            cnt_n      = 8'd0;
        end else if (bus.load && state != RUN) begin
            state_n    = IDLE;
            min_tens_n = ld_tens;
            min_ones_n = ld_ones;
            sec_tens_n = 4'd0;
            sec_ones_n = 4'd0;
        end else if (bus.start_pause) begin
            // From IDLE a zero value cannot start, so RUN never sees 00:00.
            state_n = state == IDLE  ? (is_zero ? IDLE : RUN) :
                      state == RUN   ? PAUSE :
                      state == PAUSE ? RUN : IDLE;
        end else if (bus.tick && state == RUN) begin
            min_tens_n = dec_min_tens;
            min_ones_n = dec_min_ones;
            sec_tens_n = dec_sec_tens;
            sec_ones_n = dec_sec_ones;
            if (is_one) begin
                state_n = ALARM;
                done_n  = 1'b1;
                cnt_n   = 8'd0;
            end
        end else if (bus.tick && state == ALARM) begin
            cnt_n   = cnt_inc == ALARM_LIMIT ? 8'd0 : cnt_inc;
            state_n = cnt_inc == ALARM_LIMIT ? IDLE : ALARM;
        end
    end
    assign bus.min_tens = min_tens;
    assign bus.min_ones = min_ones;
    assign bus.sec_tens = sec_tens;
    assign bus.sec_ones = sec_ones;
    assign bus.running  = state == RUN;
    assign bus.alarm    = state == ALARM;
    assign bus.done     = done;
endmodule
